// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: I/O word offsets (byte offset / 4),
// STATUS bit positions and the data-path width.
package mmio_responder_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] IO_STATUS  = 4'h0;  // byte offset 0x00
  localparam logic [3:0] IO_RX_DATA = 4'h1;  // byte offset 0x04
  localparam logic [3:0] IO_TX_DATA = 4'h2;  // byte offset 0x08
  localparam logic [3:0] IO_CYCLE   = 4'h4;  // byte offset 0x10
  localparam logic [3:0] IO_INSTR   = 4'h5;  // byte offset 0x14
  localparam logic [3:0] IO_CNT_CLR = 4'h6;  // byte offset 0x18

  localparam int STAT_TX_NOT_FULL = 0;
  localparam int STAT_RX_FULL     = 1;
  localparam int STAT_TX_OVF      = 2;

endpackage

// File: rtl/mmio_responder_if.sv
// Bus bundle between the core memory stage / BRAM / serial link and the responder.
// tx and rx are valid/ready links: a byte moves in every cycle where valid && ready are both high.
interface mmio_responder_if;
  import mmio_responder_pkg::*;

  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      wea;
  logic            re;
  logic            instr_stop;
  logic [XLEN-1:0] dmem_dout;
  logic [XLEN-1:0] dout;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;

  modport master (
    output mem_adr, mem_wdata, wea, re, instr_stop, dmem_dout, tx_ready, rx_data, rx_valid,
    input  dout, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  mem_adr, mem_wdata, wea, re, instr_stop, dmem_dout, tx_ready, rx_data, rx_valid,
    output dout, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/mmio_responder_io_fifo.sv
// Parameterised synchronous FIFO; head entry is read straight from the storage flops,
// so a push into an empty FIFO becomes visible on the following cycle.
module mmio_responder_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers run modulo 2*DEPTH; the extra MSB separates full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Data-memory-port responder: decodes I/O space, muxes load data with the BRAM,
// owns the TX FIFO, RX holding register and (with PERF_COUNTERS_EN) the perf counters.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int         TX_DEPTH    = 8,
  parameter logic [3:0] IO_BASE_NIB = 4'h8
) (
  input logic            clk,
  input logic            rst,
  mmio_responder_if.slave bus
);

  logic [3:0]      off;
  logic            io_sel, is_store, io_load, io_store;
  logic            tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]      tx_head;
  logic            tx_ovf_q, tx_ovf_d;
  logic            rx_full_q, rx_full_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            io_hit_q, io_hit_d;
  logic [XLEN-1:0] io_rdata_q, io_rdata_d;
  logic [XLEN-1:0] rdata, cycle_cnt, instr_cnt;

  // A cycle with both re and wea active is a store only.
  assign off      = bus.mem_adr[5:2];
  assign io_sel   = (bus.mem_adr[31:28] == IO_BASE_NIB);
  assign is_store = |bus.wea;
  assign io_load  = bus.re && !is_store && io_sel;
  assign io_store = is_store && io_sel;

  assign tx_push = io_store && (off == IO_TX_DATA);
  assign tx_pop  = !tx_empty && bus.tx_ready;

  mmio_responder_io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (tx_push),
    .data_i (bus.mem_wdata[7:0]),
    .pop_i  (tx_pop),
    .data_o (tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

`ifdef PERF_COUNTERS_EN
  logic [XLEN-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic            cnt_clr;

  assign cnt_clr = io_store && (off == IO_CNT_CLR);

  always_comb begin
    cycle_d = cnt_clr ? '0 : cycle_q + 32'd1;
    instr_d = cnt_clr ? '0 : (bus.instr_stop ? instr_q : instr_q + 32'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (io_store && (off == IO_STATUS))       tx_ovf_d = 1'b0;
    else if (tx_push && tx_full && !tx_pop)   tx_ovf_d = 1'b1;

    // rx_ready is low while full, so capture and pop are mutually exclusive.
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (io_load && (off == IO_RX_DATA) && rx_full_q) begin
      rx_full_d = 1'b0;
    end else if (bus.rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.rx_data;
    end

    rdata = '0;
    case (off)
      IO_STATUS: begin
        rdata[STAT_TX_NOT_FULL] = !tx_full;
        rdata[STAT_RX_FULL]     = rx_full_q;
        rdata[STAT_TX_OVF]      = tx_ovf_q;
      end
      IO_RX_DATA: if (rx_full_q) rdata[7:0] = rx_byte_q;
      IO_CYCLE:   rdata = cycle_cnt;
      IO_INSTR:   rdata = instr_cnt;
      default:    rdata = '0;
    endcase

    io_hit_d   = io_load;
    io_rdata_d = io_load ? rdata : io_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf_q   <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= '0;
      io_hit_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      tx_ovf_q   <= tx_ovf_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      io_hit_q   <= io_hit_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign bus.dout     = io_hit_q ? io_rdata_q : bus.dmem_dout;
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_head;
  assign bus.rx_ready = !rx_full_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a queue-based reference model.
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  localparam int TX_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_responder_if bus ();

  mmio_responder #(.TX_DEPTH(TX_DEPTH), .IO_BASE_NIB(4'h8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  exp_q[$];
  bit          m_ovf, m_rx_full;
  logic [7:0]  m_rx_byte;
  bit          m_exp_io;
  logic [31:0] m_exp_val;

  typedef struct {
    logic        re;
    logic        st;
    logic [3:0]  off;
    logic [7:0]  wdata;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] exp_dout;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_rxr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] io_adr(input logic [3:0] off);
    return {4'h8, 22'd0, off, 2'b00};
  endfunction

  function automatic vec_t mk(input logic re, input logic st, input logic [3:0] off,
                              input logic [7:0] wdata, input logic txr, input logic rxv,
                              input logic [7:0] rxd, input logic [31:0] exp_dout,
                              input logic txv, input logic [7:0] txd, input logic rxr);
    vec_t v;
    v.re = re; v.st = st; v.off = off; v.wdata = wdata; v.tx_ready = txr;
    v.rx_valid = rxv; v.rx_data = rxd; v.exp_dout = exp_dout;
    v.exp_txv = txv; v.exp_txd = txd; v.exp_rxr = rxr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.re = 1'b0; bus.wea = 4'h0; bus.mem_adr = '0; bus.mem_wdata = '0;
  endtask

  task automatic io_load(input logic [3:0] off);
    bus.re = 1'b1; bus.wea = 4'h0; bus.mem_adr = io_adr(off);
    step();
    drive_idle();
  endtask

  task automatic io_store(input logic [3:0] off, input logic [31:0] data);
    bus.re = 1'b0; bus.wea = 4'hF; bus.mem_adr = io_adr(off); bus.mem_wdata = data;
    step();
    drive_idle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] exp_cycle, exp_instr;
    drive_idle();
    bus.instr_stop = 1'b0; bus.dmem_dout = '0; bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    do_reset();

    check("reset_dout", bus.dout, 32'h0);
    check("reset_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
    check("reset_tx_data", {24'd0, bus.tx_data}, 32'h0);
    check("reset_rx_ready", {31'd0, bus.rx_ready}, 32'h1);

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(1, 0, IO_STATUS,  8'h00, 0, 0, 8'h00, 32'h1,  0, 8'h00, 1));
    vecs.push_back(mk(0, 1, IO_TX_DATA, 8'h41, 0, 0, 8'h00, 32'h0,  1, 8'h41, 1));
    vecs.push_back(mk(0, 1, IO_TX_DATA, 8'h42, 0, 0, 8'h00, 32'h0,  1, 8'h41, 1));
    vecs.push_back(mk(0, 1, IO_TX_DATA, 8'h43, 0, 0, 8'h00, 32'h0,  1, 8'h41, 1));
    vecs.push_back(mk(0, 0, IO_STATUS,  8'h00, 1, 0, 8'h00, 32'h0,  1, 8'h42, 1));
    vecs.push_back(mk(0, 0, IO_STATUS,  8'h00, 1, 0, 8'h00, 32'h0,  1, 8'h43, 1));
    vecs.push_back(mk(0, 0, IO_STATUS,  8'h00, 1, 0, 8'h00, 32'h0,  0, 8'h00, 1));
    vecs.push_back(mk(0, 0, IO_STATUS,  8'h00, 0, 1, 8'h5A, 32'h0,  0, 8'h00, 0));
    vecs.push_back(mk(1, 0, IO_STATUS,  8'h00, 0, 0, 8'h00, 32'h3,  0, 8'h00, 0));
    vecs.push_back(mk(1, 0, IO_RX_DATA, 8'h00, 0, 0, 8'h00, 32'h5A, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, IO_RX_DATA, 8'h00, 0, 0, 8'h00, 32'h0,  0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 4'h3,       8'h00, 0, 0, 8'h00, 32'h0,  0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h3,       8'hFF, 0, 0, 8'h00, 32'h0,  0, 8'h00, 1));
    vecs.push_back(mk(0, 0, IO_STATUS,  8'h00, 0, 1, 8'h77, 32'h0,  0, 8'h00, 0));
    vecs.push_back(mk(1, 1, IO_RX_DATA, 8'h00, 0, 0, 8'h00, 32'h0,  0, 8'h00, 0));
    vecs.push_back(mk(1, 0, IO_RX_DATA, 8'h00, 0, 0, 8'h00, 32'h77, 0, 8'h00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      bus.re = vecs[i].re;
      bus.wea = vecs[i].st ? 4'hF : 4'h0;
      bus.mem_adr = io_adr(vecs[i].off);
      bus.mem_wdata = {24'd0, vecs[i].wdata};
      bus.tx_ready = vecs[i].tx_ready;
      bus.rx_valid = vecs[i].rx_valid;
      bus.rx_data = vecs[i].rx_data;
      step();
      check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_tx_valid", i), {31'd0, bus.tx_valid}, {31'd0, vecs[i].exp_txv});
      if (vecs[i].exp_txv)
        check($sformatf("vec%0d_tx_data", i), {24'd0, bus.tx_data}, {24'd0, vecs[i].exp_txd});
      check($sformatf("vec%0d_rx_ready", i), {31'd0, bus.rx_ready}, {31'd0, vecs[i].exp_rxr});
    end
    drive_idle();
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;

    // ---------------- overflow, clear, full push+pop, drain ----------------
    exp_q.delete();
    for (int i = 0; i < TX_DEPTH + 1; i++) begin
      io_store(IO_TX_DATA, 32'h10 + i);
      if (exp_q.size() < TX_DEPTH) exp_q.push_back(8'(8'h10 + i));
    end
    io_load(IO_STATUS);
    check("ovf_status", bus.dout, 32'h4);
    check("ovf_head", {24'd0, bus.tx_data}, {24'd0, exp_q[0]});
    io_store(IO_STATUS, 32'h0);
    io_load(IO_STATUS);
    check("ovf_cleared_status", bus.dout, 32'h0);

    bus.tx_ready = 1'b1;
    io_store(IO_TX_DATA, 32'h99);
    bus.tx_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    io_load(IO_STATUS);
    check("full_pushpop_status", bus.dout, 32'h0);

    bus.tx_ready = 1'b1;
    while (exp_q.size() != 0) begin
      check("drain_valid", {31'd0, bus.tx_valid}, 32'h1);
      check("drain_data", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
      step();
    end
    check("drain_empty", {31'd0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;

    // ---------------- asynchronous reset mid-transfer ----------------
    io_store(IO_TX_DATA, 32'hC1);
    io_store(IO_TX_DATA, 32'hC2);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
    step();
    bus.rx_valid = 1'b0;
    check("pre_rst_rx_ready", {31'd0, bus.rx_ready}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
    check("async_rst_tx_data", {24'd0, bus.tx_data}, 32'h0);
    check("async_rst_rx_ready", {31'd0, bus.rx_ready}, 32'h1);
    #2 rst = 1'b1;
    step();
    io_load(IO_RX_DATA);
    check("post_rst_rx_empty", bus.dout, 32'h0);

    // ---------------- performance counters ----------------
`ifdef PERF_COUNTERS_EN
    exp_cycle = 32'd1;
    exp_instr = 32'd3;
`else
    exp_cycle = 32'd0;
    exp_instr = 32'd0;
`endif
    bus.instr_stop = 1'b1;
    repeat (10) step();
    io_store(IO_CNT_CLR, 32'h0);
    step();
    io_load(IO_CYCLE);
    check("cycle_after_clr", bus.dout, exp_cycle);
    io_load(IO_INSTR);
    check("instr_stalled", bus.dout, 32'h0);
    bus.instr_stop = 1'b0;
    io_store(IO_CNT_CLR, 32'h0);
    repeat (3) step();
    io_load(IO_INSTR);
    check("instr_counting", bus.dout, exp_instr);

    // ---------------- random traffic vs. reference model ----------------
    do_reset();
    exp_q.delete();
    m_ovf = 0; m_rx_full = 0; m_rx_byte = '0; m_exp_io = 0; m_exp_val = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int unsigned op;
      bit          pop, st, ld, io;
      logic [3:0]  off;
      bit          pre_full;
      int          pre_size;

      check("rnd_dout", bus.dout, m_exp_io ? m_exp_val : bus.dmem_dout);
      check("rnd_tx_valid", {31'd0, bus.tx_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("rnd_tx_data", {24'd0, bus.tx_data}, {24'd0, exp_q[0]});
      check("rnd_rx_ready", {31'd0, bus.rx_ready}, {31'd0, !m_rx_full});

      op = $urandom_range(0, 9);
      bus.tx_ready   = ($urandom_range(0, 3) == 0);
      bus.rx_valid   = $urandom_range(0, 1);
      bus.rx_data    = 8'($urandom);
      bus.dmem_dout  = $urandom;
      bus.instr_stop = $urandom_range(0, 1);
      bus.mem_wdata  = $urandom;
      st = 0; ld = 0; io = 1; off = IO_STATUS;
      case (op)
        1: begin ld = 1; off = IO_STATUS; end
        2: begin ld = 1; off = IO_RX_DATA; end
        3, 4: begin st = 1; off = IO_TX_DATA; end
        5: begin st = 1; off = IO_STATUS; end
        6: begin ld = 1; io = 0; off = 4'($urandom_range(0, 15)); end
        7: begin st = 1; io = 0; off = IO_TX_DATA; end
        8: begin st = 1; off = IO_RX_DATA; end
        9: begin ld = 1; off = 4'(4'd8 + $urandom_range(0, 7)); end
        default: ;
      endcase
      bus.re = ld || (op == 8);
      bus.wea = st ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      bus.mem_adr = io ? io_adr(off) : {4'h1, 22'($urandom), off, 2'b00};

      pre_full = m_rx_full;
      pre_size = exp_q.size();
      pop = (pre_size != 0) && bus.tx_ready;
      m_exp_io = ld && io;
      m_exp_val = '0;
      if (m_exp_io && off == IO_STATUS)
        m_exp_val = {29'd0, m_ovf, m_rx_full, pre_size < TX_DEPTH};
      else if (m_exp_io && off == IO_RX_DATA)
        m_exp_val = m_rx_full ? {24'd0, m_rx_byte} : 32'h0;

      if (pop) void'(exp_q.pop_front());
      if (st && io && off == IO_TX_DATA) begin
        if (pre_size < TX_DEPTH || pop) exp_q.push_back(bus.mem_wdata[7:0]);
        else m_ovf = 1;
      end
      if (st && io && off == IO_STATUS) m_ovf = 0;
      if (ld && io && off == IO_RX_DATA && pre_full) m_rx_full = 0;
      if (bus.rx_valid && !pre_full) begin
        m_rx_full = 1;
        m_rx_byte = bus.rx_data;
      end
      step();
    end
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
